// File: rtl/rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_pkg
//   Shared definitions for the round-robin / fixed-priority arbiter.
//   - RR_MAX_PORTS : widest requester vector the mask helper can describe.
//   - arb_action_e : per-cycle decision taken by the arbiter.
//   - enc_width()  : width of an encoded port index, never less than 1.
//   - rr_mask()    : round-robin mask to load after granting a given index.
// -----------------------------------------------------------------------------
package rr_arbiter_pkg;

    localparam int RR_MAX_PORTS = 64;

    typedef enum logic [1:0] {
        ARB_HOLD = 2'd0,
        ARB_NEW  = 2'd1,
        ARB_IDLE = 2'd2
    } arb_action_e;

    function automatic int enc_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // After granting idx, the next search starts just past idx in the
    // rotation direction: bits strictly above idx when index 0 is the
    // strongest, bits strictly below idx otherwise. A winner at the end of
    // the rotation yields an empty mask, which wraps to the unmasked search.
    function automatic logic [RR_MAX_PORTS-1:0] rr_mask(input int idx,
                                                        input int ports,
                                                        input bit lsb_high);
        logic [RR_MAX_PORTS-1:0] m;
        m = '0;
        for (int i = 0; i < RR_MAX_PORTS; i++) begin
            if (i < ports) begin
                m[i] = lsb_high ? (i > idx) : (i < idx);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder
//   Combinational priority encoder.
//   Ports:
//     input_unencoded  in  WIDTH      request bits
//     output_valid     out 1          any bit set
//     output_encoded   out enc_width  index of the winning bit (0 when none)
//     output_unencoded out WIDTH      one-hot winning bit (0 when none)
//   LSB_HIGH_PRIORITY=1 makes the lowest set bit win, otherwise the highest.
// -----------------------------------------------------------------------------
module priority_encoder
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]                 input_unencoded,
    output logic                             output_valid,
    output logic [enc_width(WIDTH)-1:0]      output_encoded,
    output logic [WIDTH-1:0]                 output_unencoded
);

    localparam int W = enc_width(WIDTH);

    // Scan from the weakest end toward the strongest so the last hit wins.
    always_comb begin
        output_valid     = |input_unencoded;
        output_encoded   = '0;
        output_unencoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) begin
                    output_encoded   = W'(i);
                    output_unencoded = WIDTH'(1) << i;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) begin
                    output_encoded   = W'(i);
                    output_unencoded = WIDTH'(1) << i;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Registered N-port arbiter for the interconnect address/write-channel
//   muxes. Selects one requester per decision (round-robin or fixed
//   priority) and optionally holds the grant until the requester drops its
//   request or acknowledges.
//
//   Ports:
//     clk            in  1          clock
//     rst            in  1          asynchronous, active-high reset
//     request        in  PORTS      per-port request level
//     acknowledge    in  PORTS      per-port release strobe (ACK blocking only)
//     grant          out PORTS      one-hot grant, registered
//     grant_valid    out 1          a grant is active, registered
//     grant_encoded  out enc_width  index of the granted port, registered
//     timeout_pulse  out 1          one-cycle flag on a timeout-forced grant
//                                   (only with RR_ARBITER_GRANT_TIMEOUT_EN)
//
//   Optional feature macro: RR_ARBITER_GRANT_TIMEOUT_EN
//     Adds a hold counter that forces re-arbitration after GRANT_TIMEOUT
//     cycles of holding, excluding the current holder from that search.
//
//   PORTS must not exceed rr_arbiter_pkg::RR_MAX_PORTS.
// -----------------------------------------------------------------------------
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int PORTS                = 4,
    parameter int ARB_TYPE_ROUND_ROBIN = 1,
    parameter int ARB_BLOCK            = 1,
    parameter int ARB_BLOCK_ACK        = 1,
    parameter int LSB_HIGH_PRIORITY    = 0,
    parameter int GRANT_TIMEOUT        = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORTS-1:0]             request,
    input  logic [PORTS-1:0]             acknowledge,
    output logic [PORTS-1:0]             grant,
    output logic                         grant_valid,
    output logic [enc_width(PORTS)-1:0]  grant_encoded
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
    ,
    output logic                         timeout_pulse
`endif
);

    localparam int EW = enc_width(PORTS);

    logic [PORTS-1:0]        grant_q, grant_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [EW-1:0]           grant_enc_q, grant_enc_d;
    logic [PORTS-1:0]        mask_q, mask_d;

    logic                    hold;
    logic                    hold_eff;
    logic [PORTS-1:0]        arb_req;
    logic                    unm_valid, msk_valid;
    logic [EW-1:0]           unm_enc, msk_enc;
    logic [PORTS-1:0]        unm_oh, msk_oh;
    logic [EW-1:0]           win_enc;
    logic [PORTS-1:0]        win_oh;
    logic [RR_MAX_PORTS-1:0] mask_full;
    logic                    unused_mask_bits;
    arb_action_e             action;

    // Hold condition for the current grant. In ACK mode a dropped request
    // does not release the port; only an ack on the granted port does.
    always_comb begin
        hold = 1'b0;
        if (ARB_BLOCK != 0 && grant_valid_q) begin
            if (ARB_BLOCK_ACK != 0) begin
                hold = ~|(grant_q & acknowledge);
            end else begin
                hold = |(grant_q & request);
            end
        end
    end

`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
    localparam int CW = $clog2(GRANT_TIMEOUT + 1);

    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             timeout_pulse_q, timeout_pulse_d;
    logic             tmo_hit;
    logic [PORTS-1:0] others_req;

    // A timeout overrides the hold and searches among the other requesters;
    // if the holder is the only one left it may win again.
    assign tmo_hit    = hold && (hold_cnt_q == CW'(GRANT_TIMEOUT - 1));
    assign others_req = request & ~grant_q;
    assign hold_eff   = hold && !tmo_hit;
    assign arb_req    = (tmo_hit && |others_req) ? others_req : request;
`else
    assign hold_eff   = hold;
    assign arb_req    = request;
`endif

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_unmasked (
        .input_unencoded  (arb_req),
        .output_valid     (unm_valid),
        .output_encoded   (unm_enc),
        .output_unencoded (unm_oh)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .input_unencoded  (arb_req & mask_q),
        .output_valid     (msk_valid),
        .output_encoded   (msk_enc),
        .output_unencoded (msk_oh)
    );

    // Round robin prefers requesters past the last winner; an empty masked
    // set wraps to the plain priority search.
    always_comb begin
        if (ARB_TYPE_ROUND_ROBIN != 0 && msk_valid) begin
            win_enc = msk_enc;
            win_oh  = msk_oh;
        end else begin
            win_enc = unm_enc;
            win_oh  = unm_oh;
        end
    end

    always_comb begin
        if (hold_eff) begin
            action = ARB_HOLD;
        end else if (unm_valid) begin
            action = ARB_NEW;
        end else begin
            action = ARB_IDLE;
        end
    end

    // Release and re-arbitration share a cycle, so there is no idle bubble
    // between back-to-back grants. The mask only moves on a new grant.
    always_comb begin
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_enc_d   = grant_enc_q;
        mask_d        = mask_q;
        mask_full     = rr_mask(int'(win_enc), PORTS, LSB_HIGH_PRIORITY != 0);
        case (action)
            ARB_HOLD: begin
            end
            ARB_NEW: begin
                grant_d       = win_oh;
                grant_valid_d = 1'b1;
                grant_enc_d   = win_enc;
                if (ARB_TYPE_ROUND_ROBIN != 0) begin
                    mask_d = mask_full[PORTS-1:0];
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_enc_d   = '0;
            end
        endcase
    end

    // Bits of the helper result above PORTS are always zero.
    assign unused_mask_bits = ^mask_full;

`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
    always_comb begin
        hold_cnt_d      = (action == ARB_HOLD) ? hold_cnt_q + CW'(1) : '0;
        timeout_pulse_d = tmo_hit && (action == ARB_NEW);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            grant_enc_q     <= '0;
            mask_q          <= '0;
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
            hold_cnt_q      <= '0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
            grant_q         <= grant_d;
            grant_valid_q   <= grant_valid_d;
            grant_enc_q     <= grant_enc_d;
            mask_q          <= mask_d;
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
            hold_cnt_q      <= hold_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = grant_valid_q;
    assign grant_encoded = grant_enc_q;
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
    assign timeout_pulse = timeout_pulse_q;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//   Five arbiter configurations driven from shared request/acknowledge
//   inputs, each compared every cycle against a rotation-pointer model,
//   with directed scenarios and randomized traffic.
//     a: RR, ACK blocking, LSB high, GRANT_TIMEOUT=4
//     b: RR, no blocking, LSB high
//     c: fixed priority, no blocking, MSB high
//     d: RR, request blocking, MSB high
//     e: PORTS=1, request blocking
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

    typedef struct packed {
        int ports;
        bit rr;
        bit blk;
        bit ackm;
        bit lsb;
        bit tmo;
        int tlim;
    } cfg_t;

    // last = most recent round-robin winner; the next search starts after it.
    typedef struct packed {
        bit vld;
        int idx;
        int last;
        int cnt;
        bit pulse;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] request, acknowledge;

    logic [3:0] g_a, g_b, g_c, g_d;
    logic       g_e;
    logic       v_a, v_b, v_c, v_d, v_e;
    logic [1:0] e_a, e_b, e_c, e_d;
    logic       e_e;
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
    logic       tp_a, tp_b, tp_c, tp_d, tp_e;
`endif

    cfg_t cfg[5];
    mst_t ms[5];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                 .LSB_HIGH_PRIORITY(1), .GRANT_TIMEOUT(4)) u_a (
        .clk (clk), .rst (rst), .request (request), .acknowledge (acknowledge),
        .grant (g_a), .grant_valid (v_a), .grant_encoded (e_a)
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        , .timeout_pulse (tp_a)
`endif
    );

    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                 .LSB_HIGH_PRIORITY(1)) u_b (
        .clk (clk), .rst (rst), .request (request), .acknowledge (acknowledge),
        .grant (g_b), .grant_valid (v_b), .grant_encoded (e_b)
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        , .timeout_pulse (tp_b)
`endif
    );

    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
                 .LSB_HIGH_PRIORITY(0)) u_c (
        .clk (clk), .rst (rst), .request (request), .acknowledge (acknowledge),
        .grant (g_c), .grant_valid (v_c), .grant_encoded (e_c)
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        , .timeout_pulse (tp_c)
`endif
    );

    rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                 .LSB_HIGH_PRIORITY(0)) u_d (
        .clk (clk), .rst (rst), .request (request), .acknowledge (acknowledge),
        .grant (g_d), .grant_valid (v_d), .grant_encoded (e_d)
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        , .timeout_pulse (tp_d)
`endif
    );

    rr_arbiter #(.PORTS(1), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                 .LSB_HIGH_PRIORITY(0)) u_e (
        .clk (clk), .rst (rst), .request (request[0]), .acknowledge (acknowledge[0]),
        .grant (g_e), .grant_valid (v_e), .grant_encoded (e_e)
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        , .timeout_pulse (tp_e)
`endif
    );

    // ---------------- reference model ----------------
    function automatic mst_t mreset(input cfg_t c);
        mst_t s;
        s.vld   = 1'b0;
        s.idx   = 0;
        s.last  = c.lsb ? c.ports - 1 : 0;
        s.cnt   = 0;
        s.pulse = 1'b0;
        return s;
    endfunction

    function automatic int pick(input cfg_t c, input int last, input logic [3:0] r);
        int j;
        if (c.rr) begin
            for (int k = 1; k <= c.ports; k++) begin
                j = c.lsb ? (last + k) % c.ports : (last - k + 2 * c.ports) % c.ports;
                if (r[j]) return j;
            end
        end else if (c.lsb) begin
            for (int k = 0; k < c.ports; k++) if (r[k]) return k;
        end else begin
            for (int k = c.ports - 1; k >= 0; k--) if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic mst_t mstep(input cfg_t c, input mst_t s,
                                   input logic [3:0] req_in, input logic [3:0] ack);
        mst_t       n;
        logic [3:0] r, others;
        bit         hold, tmo;
        int         w;
        n       = s;
        n.pulse = 1'b0;
        hold    = 1'b0;
        tmo     = 1'b0;
        r       = req_in & 4'((1 << c.ports) - 1);
        if (c.blk && s.vld) hold = c.ackm ? !ack[s.idx] : r[s.idx];
        if (hold && c.tmo && s.cnt == c.tlim - 1) begin
            hold = 1'b0;
            tmo  = 1'b1;
        end
        if (hold) begin
            n.cnt = s.cnt + 1;
            return n;
        end
        n.cnt  = 0;
        others = r & ~(4'b0001 << s.idx);
        if (tmo && others != 4'b0000) r = others;
        w = pick(c, s.last, r);
        if (w < 0) begin
            n.vld = 1'b0;
            n.idx = 0;
        end else begin
            n.vld   = 1'b1;
            n.idx   = w;
            n.pulse = tmo;
            if (c.rr) n.last = w;
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] og[5];
        logic       ov[5];
        logic [1:0] oe[5];
        logic [3:0] eg;
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        logic       otp[5];
        otp[0] = tp_a; otp[1] = tp_b; otp[2] = tp_c; otp[3] = tp_d; otp[4] = tp_e;
`endif
        og[0] = g_a; og[1] = g_b; og[2] = g_c; og[3] = g_d; og[4] = {3'b000, g_e};
        ov[0] = v_a; ov[1] = v_b; ov[2] = v_c; ov[3] = v_d; ov[4] = v_e;
        oe[0] = e_a; oe[1] = e_b; oe[2] = e_c; oe[3] = e_d; oe[4] = {1'b0, e_e};
        for (int i = 0; i < 5; i++) begin
            eg = ms[i].vld ? (4'b0001 << ms[i].idx) : 4'b0000;
            chk($sformatf("%s.grant[%0d]", tag, i), 32'(og[i]), 32'(eg));
            chk($sformatf("%s.valid[%0d]", tag, i), 32'(ov[i]), 32'(ms[i].vld));
            chk($sformatf("%s.enc[%0d]", tag, i), 32'(oe[i]),
                ms[i].vld ? 32'(ms[i].idx) : 32'd0);
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
            chk($sformatf("%s.tpulse[%0d]", tag, i), 32'(otp[i]), 32'(ms[i].pulse));
`endif
        end
    endtask

    task automatic step(input string tag, input logic [3:0] req, input logic [3:0] ack);
        request     = req;
        acknowledge = ack;
        @(posedge clk);
        for (int i = 0; i < 5; i++) ms[i] = mstep(cfg[i], ms[i], req, ack);
        #1;
        check_all(tag);
    endtask

    // Reset raised between edges; outputs must clear without waiting for clk.
    task automatic do_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) ms[i] = mreset(cfg[i]);
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit tmo_on;
`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        tmo_on = 1'b1;
`else
        tmo_on = 1'b0;
`endif
        cfg[0] = '{ports: 4, rr: 1, blk: 1, ackm: 1, lsb: 1, tmo: tmo_on, tlim: 4};
        cfg[1] = '{ports: 4, rr: 1, blk: 0, ackm: 0, lsb: 1, tmo: tmo_on, tlim: 256};
        cfg[2] = '{ports: 4, rr: 0, blk: 0, ackm: 0, lsb: 0, tmo: tmo_on, tlim: 256};
        cfg[3] = '{ports: 4, rr: 1, blk: 1, ackm: 0, lsb: 0, tmo: tmo_on, tlim: 256};
        cfg[4] = '{ports: 1, rr: 1, blk: 1, ackm: 0, lsb: 0, tmo: tmo_on, tlim: 256};

        rst         = 1'b1;
        request     = 4'b0000;
        acknowledge = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) ms[i] = mreset(cfg[i]);
        check_all("reset");
        chk("reset.grant_a", 32'(g_a), 32'd0);
        rst = 1'b0;

        // Reset mid-grant, then a fresh grant one edge after release.
        step("midrst.grant", 4'b0100, 4'b0000);
        step("midrst.hold", 4'b0100, 4'b0000);
        chk("midrst.held_a", 32'(g_a), 32'b0100);
        do_reset("midrst.async");
        chk("midrst.cleared_a", 32'(g_a), 32'd0);
        chk("midrst.valid_a", 32'(v_a), 32'd0);
        step("midrst.after", 4'b0010, 4'b0000);
        chk("midrst.regrant_a", 32'(g_a), 32'b0010);

        // Round-robin rotation without blocking, including the mask wrap.
        do_reset("rot.rst");
        step("rot.1", 4'b1011, 4'b0000);
        chk("rot.1_b", 32'(g_b), 32'b0001);
        step("rot.2", 4'b1011, 4'b0000);
        chk("rot.2_b", 32'(g_b), 32'b0010);
        step("rot.3", 4'b1011, 4'b0000);
        chk("rot.3_b", 32'(g_b), 32'b1000);
        step("rot.4", 4'b1011, 4'b0000);
        chk("rot.4_b", 32'(g_b), 32'b0001);

        // Fixed priority, highest index wins.
        step("fix.1", 4'b0110, 4'b0000);
        chk("fix.1_c", 32'(e_c), 32'd2);
        step("fix.2", 4'b0110, 4'b0000);
        chk("fix.2_c", 32'(e_c), 32'd2);
        step("fix.3", 4'b0010, 4'b0000);
        chk("fix.3_c", 32'(e_c), 32'd1);

        // ACK blocking: dropped request and foreign ack do not release.
        do_reset("ack.rst");
        step("ack.1", 4'b0001, 4'b0000);
        chk("ack.1_a", 32'(g_a), 32'b0001);
        step("ack.2", 4'b0000, 4'b0000);
        chk("ack.2_a", 32'(g_a), 32'b0001);
        step("ack.3", 4'b0000, 4'b0100);
        chk("ack.3_a", 32'(g_a), 32'b0001);
        step("ack.4", 4'b1000, 4'b0001);
        chk("ack.4_a", 32'(g_a), 32'b1000);

        // Request blocking: hand-over without an idle cycle.
        do_reset("reqblk.rst");
        step("reqblk.1", 4'b0010, 4'b0000);
        chk("reqblk.1_d", 32'(g_d), 32'b0010);
        step("reqblk.2", 4'b0110, 4'b0000);
        chk("reqblk.2_d", 32'(g_d), 32'b0010);
        step("reqblk.3", 4'b0100, 4'b0000);
        chk("reqblk.3_d", 32'(g_d), 32'b0100);

        // Single-port instance and same-cycle request+ack regrant.
        do_reset("p1.rst");
        step("p1.1", 4'b0001, 4'b0000);
        chk("p1.1_e", 32'(g_e), 32'd1);
        step("p1.2", 4'b0001, 4'b0001);
        chk("p1.2_e", 32'(g_e), 32'd1);
        chk("p1.2_a_valid", 32'(v_a), 32'd1);
        chk("p1.2_a", 32'(g_a), 32'b0001);
        step("p1.3", 4'b0000, 4'b0000);
        chk("p1.3_e", 32'(v_e), 32'd0);

`ifdef RR_ARBITER_GRANT_TIMEOUT_EN
        // Port 0 held four cycles without ack, then forced hand-over.
        do_reset("tmo.rst");
        for (int k = 0; k < 4; k++) begin
            step("tmo.hold", 4'b0011, 4'b0000);
            chk("tmo.hold_a", 32'(g_a), 32'b0001);
            chk("tmo.hold_pulse", 32'(tp_a), 32'd0);
        end
        step("tmo.fire", 4'b0011, 4'b0000);
        chk("tmo.fire_a", 32'(g_a), 32'b0010);
        chk("tmo.fire_pulse", 32'(tp_a), 32'd1);
        step("tmo.after", 4'b0011, 4'b0000);
        chk("tmo.after_pulse", 32'(tp_a), 32'd0);
`endif

        // Randomized traffic with occasional resets.
        do_reset("rnd.rst");
        for (int n = 0; n < 600; n++) begin
            if (n % 97 == 96) do_reset("rnd.rst");
            step("rnd", 4'($urandom), 4'($urandom & $urandom));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
